// File: rtl/hsv_core_mem_response.sv
// In-order load/store response stage: queues address-stage transactions, consumes dmem responses,
// formats load data and emits one commit record per instruction. Optional macro: HSV_MEM_ACCESS_FAULT_EN.
package hsv_core_mem_pkg;
  typedef struct packed {
    logic write;
    logic sign_extend;
  } mem_data_t;

  typedef struct packed {
    logic [31:0] address;
    mem_data_t   mem_data;
    logic        is_memory;
    logic [3:0]  write_strobe;
    logic        misaligned_address;
  } read_write_t;

  typedef struct packed {
    logic       is_store;
    logic       sign_extend;
    logic       is_memory;
    logic       misaligned;
    logic [3:0] strobe;
    logic       bus;
  } q_entry_t;
endpackage

module hsv_core_mem_response
  import hsv_core_mem_pkg::*;
#(
  parameter int unsigned QueueDepth = 4
) (
  input  logic        clk_core,
  input  logic        rst_core_n,
  input  logic        flush,
  input  read_write_t transaction,
  input  logic        valid_i,
  output logic        response_stall,
  input  logic        dmem_rvalid,
  output logic        dmem_rready,
  input  logic [31:0] dmem_rdata,
  input  logic [1:0]  dmem_rresp,
  input  logic        dmem_bvalid,
  output logic        dmem_bready,
  input  logic [1:0]  dmem_bresp,
  input  logic        commit_stall,
  output logic        commit_valid_o,
  output logic [31:0] commit_data,
  output logic        commit_trap,
  output logic [3:0]  commit_cause
);
  localparam int unsigned PtrW = $clog2(QueueDepth);
  localparam int unsigned CntW = PtrW + 1;

  q_entry_t              r_queue [QueueDepth];
  logic [QueueDepth-1:0] r_discard;
  logic [PtrW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]       r_count;
  logic                  r_stall;
  logic                  r_commit_valid, r_commit_trap;
  logic [31:0]           r_commit_data;
  logic [3:0]            r_commit_cause;

  q_entry_t        w_new, w_head;
  logic            w_enq, w_bypass, w_head_valid, w_head_discard;
  logic            w_out_free, w_can_complete, w_pop, w_record, w_bus_err;
  logic [CntW-1:0] w_count_next;
  logic [1:0]      w_off;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_load, w_data;
  logic            w_trap;
  logic [3:0]      w_cause;
  logic            w_unused_bits;

  assign w_new.is_store    = transaction.mem_data.write;
  assign w_new.sign_extend = transaction.mem_data.sign_extend;
  assign w_new.is_memory   = transaction.is_memory;
  assign w_new.misaligned  = transaction.misaligned_address;
  assign w_new.strobe      = transaction.write_strobe;
  assign w_new.bus         = transaction.is_memory & ~transaction.misaligned_address;

  assign w_enq    = valid_i & ~r_stall & ~flush;
  // A non-bus entry arriving at an empty queue is completed in its enqueue cycle.
  assign w_bypass = (r_count == '0) & w_enq & ~w_new.bus;

  assign w_head         = w_bypass ? w_new : r_queue[r_rd_ptr];
  assign w_head_valid   = (r_count != '0) | w_bypass;
  assign w_head_discard = ~w_bypass & (r_discard[r_rd_ptr] | flush);
  assign w_out_free     = ~r_commit_valid | ~commit_stall;
  assign w_can_complete = w_head_valid & (w_head_discard | w_out_free);

  assign dmem_rready = w_can_complete & w_head.bus & ~w_head.is_store;
  assign dmem_bready = w_can_complete & w_head.bus & w_head.is_store;
  assign w_pop       = w_can_complete & (~w_head.bus | (dmem_rready & dmem_rvalid)
                                                     | (dmem_bready & dmem_bvalid));
  assign w_record    = w_pop & ~w_head_discard;
  assign w_count_next = r_count + CntW'(w_enq) - CntW'(w_pop);

`ifdef HSV_MEM_ACCESS_FAULT_EN
  assign w_bus_err     = w_head.bus & (w_head.is_store ? (dmem_bresp != 2'b00) : (dmem_rresp != 2'b00));
  assign w_unused_bits = ^transaction.address;
`else
  assign w_bus_err     = 1'b0;
  assign w_unused_bits = ^{transaction.address, dmem_rresp, dmem_bresp};
`endif

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_off = 2'd0;
    if      (w_head.strobe[0]) w_off = 2'd0;
    else if (w_head.strobe[1]) w_off = 2'd1;
    else if (w_head.strobe[2]) w_off = 2'd2;
    else if (w_head.strobe[3]) w_off = 2'd3;

    w_half = w_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (w_off)
      2'd0:    w_byte = dmem_rdata[7:0];
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase

    if (&w_head.strobe)
      w_load = dmem_rdata;
    else if ((w_head.strobe == 4'b0011) || (w_head.strobe == 4'b1100))
      w_load = {{16{w_head.sign_extend & w_half[15]}}, w_half};
    else
      w_load = {{24{w_head.sign_extend & w_byte[7]}}, w_byte};

    w_trap  = 1'b0;
    w_cause = 4'd0;
    if (w_head.misaligned) begin
      w_trap  = 1'b1;
      w_cause = w_head.is_store ? 4'd6 : 4'd4;
    end else if (!w_head.is_memory || w_bus_err) begin
      w_trap  = 1'b1;
      w_cause = w_head.is_store ? 4'd7 : 4'd5;
    end
    w_data = (w_trap | w_head.is_store) ? 32'd0 : w_load;
  end

  // NOTE: queue storage has no reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk_core) begin
    if (w_enq) r_queue[r_wr_ptr] <= w_new;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_discard      <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_stall        <= 1'b0;
      r_commit_valid <= 1'b0;
      r_commit_data  <= 32'd0;
      r_commit_trap  <= 1'b0;
      r_commit_cause <= 4'd0;
    end else begin
      if (flush) r_discard <= '1;
      else if (w_enq) r_discard[r_wr_ptr] <= 1'b0;
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_stall <= (w_count_next == CntW'(QueueDepth));

      if (flush) begin
        r_commit_valid <= 1'b0;
      end else if (w_record) begin
        r_commit_valid <= 1'b1;
        r_commit_data  <= w_data;
        r_commit_trap  <= w_trap;
        r_commit_cause <= w_cause;
      end else if (!commit_stall) begin
        r_commit_valid <= 1'b0;
      end
    end
  end

  assign response_stall = r_stall;
  assign commit_valid_o = r_commit_valid;
  assign commit_data    = r_commit_data;
  assign commit_trap    = r_commit_trap;
  assign commit_cause   = r_commit_cause;
endmodule

// File: tb/tb_hsv_core_mem_response.sv
// Directed bench for hsv_core_mem_response: load formatting, traps, stall/backpressure, flush drain.
module tb_hsv_core_mem_response;
  import hsv_core_mem_pkg::*;

  logic        clk_core = 1'b0;
  logic        rst_core_n, flush, valid_i, commit_stall;
  read_write_t transaction;
  logic        response_stall;
  logic        dmem_rvalid, dmem_rready, dmem_bvalid, dmem_bready;
  logic [31:0] dmem_rdata;
  logic [1:0]  dmem_rresp, dmem_bresp;
  logic        commit_valid_o, commit_trap;
  logic [31:0] commit_data;
  logic [3:0]  commit_cause;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_core = ~clk_core;

  hsv_core_mem_response #(.QueueDepth(4)) dut (
    .clk_core(clk_core), .rst_core_n(rst_core_n), .flush(flush),
    .transaction(transaction), .valid_i(valid_i), .response_stall(response_stall),
    .dmem_rvalid(dmem_rvalid), .dmem_rready(dmem_rready), .dmem_rdata(dmem_rdata),
    .dmem_rresp(dmem_rresp), .dmem_bvalid(dmem_bvalid), .dmem_bready(dmem_bready),
    .dmem_bresp(dmem_bresp), .commit_stall(commit_stall), .commit_valid_o(commit_valid_o),
    .commit_data(commit_data), .commit_trap(commit_trap), .commit_cause(commit_cause)
  );

  function automatic read_write_t mk(input logic wr, input logic sext, input logic mem,
                                     input logic mis, input logic [3:0] strobe);
    read_write_t t;
    t.address            = 32'h0000_1000;
    t.mem_data.write     = wr;
    t.mem_data.sign_extend = sext;
    t.is_memory          = mem;
    t.write_strobe       = strobe;
    t.misaligned_address = mis;
    return t;
  endfunction

  // Advance one clock; inputs are changed and outputs sampled 2 time units after the edge.
  task automatic step();
    @(posedge clk_core);
    #2;
  endtask

  task automatic test_reset();
    rst_core_n = 1'b0; flush = 1'b0; valid_i = 1'b0; commit_stall = 1'b0;
    transaction = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
    dmem_rvalid = 1'b0; dmem_rdata = 32'd0; dmem_rresp = 2'b00;
    dmem_bvalid = 1'b0; dmem_bresp = 2'b00;
    step(); step();
    n_cmp++; if (commit_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b exp 0", commit_valid_o); end
    n_cmp++; if (commit_data !== 32'd0) begin n_bad++; $display("FAIL rst_data got %h exp 0", commit_data); end
    n_cmp++; if ({commit_trap, commit_cause} !== 5'd0) begin n_bad++; $display("FAIL rst_trap got %b/%0d exp 0/0", commit_trap, commit_cause); end
    n_cmp++; if (response_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b exp 0", response_stall); end
    n_cmp++; if ({dmem_rready, dmem_bready} !== 2'b00) begin n_bad++; $display("FAIL rst_ready got %b exp 00", {dmem_rready, dmem_bready}); end
    rst_core_n = 1'b1;
    step();
  endtask

  task automatic test_load_format();
    // lb, sign extend, byte lane 2
    transaction = mk(1'b0, 1'b1, 1'b1, 1'b0, 4'b0100); valid_i = 1'b1;
    step(); valid_i = 1'b0; #1;
    n_cmp++; if (dmem_rready !== 1'b1) begin n_bad++; $display("FAIL lb_rready got %b exp 1", dmem_rready); end
    n_cmp++; if (commit_valid_o !== 1'b0) begin n_bad++; $display("FAIL lb_early_valid got %b exp 0", commit_valid_o); end
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1280_3456;
    step(); dmem_rvalid = 1'b0;
    n_cmp++; if (commit_valid_o !== 1'b1) begin n_bad++; $display("FAIL lb_valid got %b exp 1", commit_valid_o); end
    n_cmp++; if (commit_data !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_data got %h exp ffffff80", commit_data); end
    n_cmp++; if (commit_trap !== 1'b0) begin n_bad++; $display("FAIL lb_trap got %b exp 0", commit_trap); end
    // lhu, upper half
    transaction = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'b1100); valid_i = 1'b1;
    step(); valid_i = 1'b0;
    n_cmp++; if (commit_valid_o !== 1'b0) begin n_bad++; $display("FAIL lb_one_shot got %b exp 0", commit_valid_o); end
    dmem_rvalid = 1'b1; dmem_rdata = 32'hBEEF_1234;
    step(); dmem_rvalid = 1'b0;
    n_cmp++; if (commit_data !== 32'h0000_BEEF) begin n_bad++; $display("FAIL lhu_data got %h exp 0000beef", commit_data); end
    // lh, sign extend, lower half
    transaction = mk(1'b0, 1'b1, 1'b1, 1'b0, 4'b0011); valid_i = 1'b1;
    step(); valid_i = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_8001;
    step(); dmem_rvalid = 1'b0;
    n_cmp++; if (commit_data !== 32'hFFFF_8001) begin n_bad++; $display("FAIL lh_data got %h exp ffff8001", commit_data); end
    step();
  endtask

  task automatic test_trap_order();
    transaction = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'hF); valid_i = 1'b1; #1;
    n_cmp++; if (dmem_rready !== 1'b0) begin n_bad++; $display("FAIL mis_rready got %b exp 0", dmem_rready); end
    step();
    n_cmp++; if ({commit_valid_o, commit_trap, commit_cause} !== 6'b1_1_0100) begin
      n_bad++; $display("FAIL mis_trap got v%b t%b c%0d exp v1 t1 c4", commit_valid_o, commit_trap, commit_cause); end
    n_cmp++; if (commit_data !== 32'd0) begin n_bad++; $display("FAIL mis_data got %h exp 0", commit_data); end
    transaction = mk(1'b1, 1'b0, 1'b1, 1'b0, 4'hF);
    step(); valid_i = 1'b0; #1;
    n_cmp++; if ({dmem_bready, dmem_rready} !== 2'b10) begin n_bad++; $display("FAIL sw_ready got %b exp 10", {dmem_bready, dmem_rready}); end
    n_cmp++; if (commit_valid_o !== 1'b0) begin n_bad++; $display("FAIL sw_wait got %b exp 0", commit_valid_o); end
    dmem_bvalid = 1'b1;
    step(); dmem_bvalid = 1'b0;
    n_cmp++; if ({commit_valid_o, commit_trap, commit_data} !== {2'b10, 32'd0}) begin
      n_bad++; $display("FAIL sw_commit got v%b t%b d%h exp v1 t0 d0", commit_valid_o, commit_trap, commit_data); end
    // store with error response
    transaction = mk(1'b1, 1'b0, 1'b1, 1'b0, 4'hF); valid_i = 1'b1;
    step(); valid_i = 1'b0;
    dmem_bvalid = 1'b1; dmem_bresp = 2'b10;
    step(); dmem_bvalid = 1'b0; dmem_bresp = 2'b00;
`ifdef HSV_MEM_ACCESS_FAULT_EN
    n_cmp++; if ({commit_valid_o, commit_trap, commit_cause} !== 6'b1_1_0111) begin
      n_bad++; $display("FAIL sw_fault got v%b t%b c%0d exp v1 t1 c7", commit_valid_o, commit_trap, commit_cause); end
`else
    n_cmp++; if ({commit_valid_o, commit_trap} !== 2'b10) begin
      n_bad++; $display("FAIL sw_fault got v%b t%b exp v1 t0", commit_valid_o, commit_trap); end
`endif
    step();
  endtask

  task automatic test_back_to_back();
    transaction = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'hF); valid_i = 1'b1;
    step(); step(); step();
    n_cmp++; if (response_stall !== 1'b0) begin n_bad++; $display("FAIL stall_at3 got %b exp 0", response_stall); end
    step();
    n_cmp++; if (response_stall !== 1'b1) begin n_bad++; $display("FAIL stall_at4 got %b exp 1", response_stall); end
    // offered while full: must not be taken
    transaction = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
    step(); valid_i = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hA0;
    step();
    n_cmp++; if ({commit_valid_o, commit_data} !== {1'b1, 32'hA0}) begin
      n_bad++; $display("FAIL ord0 got v%b d%h exp v1 d000000a0", commit_valid_o, commit_data); end
    n_cmp++; if (response_stall !== 1'b0) begin n_bad++; $display("FAIL stall_drop got %b exp 0", response_stall); end
    commit_stall = 1'b1; dmem_rdata = 32'hA1; #1;
    n_cmp++; if (dmem_rready !== 1'b0) begin n_bad++; $display("FAIL hold_rready got %b exp 0", dmem_rready); end
    step();
    n_cmp++; if ({commit_valid_o, commit_data} !== {1'b1, 32'hA0}) begin
      n_bad++; $display("FAIL hold_data got v%b d%h exp v1 d000000a0", commit_valid_o, commit_data); end
    commit_stall = 1'b0;
    step();
    n_cmp++; if (commit_data !== 32'hA1) begin n_bad++; $display("FAIL ord1 got %h exp 000000a1", commit_data); end
    dmem_rdata = 32'hA2;
    step();
    n_cmp++; if (commit_data !== 32'hA2) begin n_bad++; $display("FAIL ord2 got %h exp 000000a2", commit_data); end
    dmem_rdata = 32'hA3;
    step(); dmem_rvalid = 1'b0;
    n_cmp++; if ({commit_valid_o, commit_data} !== {1'b1, 32'hA3}) begin
      n_bad++; $display("FAIL ord3 got v%b d%h exp v1 d000000a3", commit_valid_o, commit_data); end
    step();
    n_cmp++; if ({commit_valid_o, dmem_rready} !== 2'b00) begin
      n_bad++; $display("FAIL drained got v%b r%b exp v0 r0", commit_valid_o, dmem_rready); end
  endtask

  task automatic test_flush();
    transaction = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'hF); valid_i = 1'b1;
    step(); step(); valid_i = 1'b0;
    flush = 1'b1;
    step(); flush = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF; #1;
    n_cmp++; if (dmem_rready !== 1'b1) begin n_bad++; $display("FAIL fl_rready0 got %b exp 1", dmem_rready); end
    step();
    n_cmp++; if ({commit_valid_o, dmem_rready} !== 2'b01) begin
      n_bad++; $display("FAIL fl_pop0 got v%b r%b exp v0 r1", commit_valid_o, dmem_rready); end
    step(); dmem_rvalid = 1'b0;
    n_cmp++; if ({commit_valid_o, dmem_rready, response_stall} !== 3'b000) begin
      n_bad++; $display("FAIL fl_empty got v%b r%b s%b exp 000", commit_valid_o, dmem_rready, response_stall); end
    // non-memory load after drain: commits the cycle after enqueue, cause 5
    transaction = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'hF); valid_i = 1'b1;
    step(); valid_i = 1'b0;
    n_cmp++; if ({commit_valid_o, commit_trap, commit_cause} !== 6'b1_1_0101) begin
      n_bad++; $display("FAIL nonmem got v%b t%b c%0d exp v1 t1 c5", commit_valid_o, commit_trap, commit_cause); end
    step();
  endtask

  initial begin
    test_reset();
    test_load_format();
    test_trap_order();
    test_back_to_back();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
